// File: rtl/ddr4_init_seq_pkg.sv
// Shared types and constants for the DDR4 power-up / mode-register initialisation sequencer.
package ddr_package;

    typedef enum logic [3:0] {
        IDLE, CKE_LOW, CKE_SETUP, XPR_WAIT, MRS_ISSUE, MRD_WAIT,
        MOD_WAIT, ZQ_ISSUE, ZQ_WAIT, DONE, ERR
    } state_t;

    typedef enum logic [1:0] {
        CMD_DES  = 2'd0,
        CMD_MRS  = 2'd1,
        CMD_ZQCL = 2'd2
    } cmd_t;

    // addr = {BG0,BA1,BA0} selects the MR; a[17:0] is the address-bus payload.
    // Fields: MR0 bl a[1:0], rd a[6:4]/a[2], DLL reset a[8]; MR1 DLL en a[0], al a[4:3];
    // MR2 wr a[11:9]; MR4 r_pre a[11], w_pre a[12]; MR6 cas a[13:10]; MR3/MR5 all zero.
    typedef struct packed {
        logic [2:0]  addr;
        logic [17:0] a;
    } mode_register_type;

    localparam logic [2:0] MR0_ADDR = 3'd0;
    localparam logic [2:0] MR1_ADDR = 3'd1;
    localparam logic [2:0] MR2_ADDR = 3'd2;
    localparam logic [2:0] MR3_ADDR = 3'd3;
    localparam logic [2:0] MR4_ADDR = 3'd4;
    localparam logic [2:0] MR5_ADDR = 3'd5;
    localparam logic [2:0] MR6_ADDR = 3'd6;

    typedef struct packed {
        logic [4:0] cas_dly;
        logic [4:0] wr_dly;
        logic [4:0] rd_dly;
        logic       w_pre;
        logic       r_pre;
        logic [1:0] al_dly;
        logic [1:0] burst_length;
    } cfg_t;

    function automatic logic [2:0] mr_order(input logic [2:0] step);
        case (step)
            3'd0:    return MR3_ADDR;
            3'd1:    return MR6_ADDR;
            3'd2:    return MR5_ADDR;
            3'd3:    return MR4_ADDR;
            3'd4:    return MR2_ADDR;
            3'd5:    return MR1_ADDR;
            default: return MR0_ADDR;
        endcase
    endfunction

    function automatic logic cfg_legal(input cfg_t c);
        return (c.cas_dly >= 5'd9)  && (c.cas_dly <= 5'd16) &&
               (c.wr_dly  >= 5'd10) && (c.wr_dly  <= 5'd24) && !c.wr_dly[0] &&
               (c.rd_dly  >= 5'd9)  && (c.rd_dly  <= 5'd24);
    endfunction

endpackage

// File: rtl/ddr4_init_seq_mr_encode.sv
// Combinational assembly of one DDR4 mode-register word from the captured configuration.
module ddr4_mr_encode
    import ddr_package::*;
(
    input  logic [2:0]        mr_idx,
    input  cfg_t              cfg,
    output mode_register_type mode_reg
);

    logic [3:0] cas;
    logic [2:0] wr;
    logic [3:0] rd;

    always_comb begin
        cas = 4'(cfg.cas_dly - 5'd9);
        wr  = 3'((cfg.wr_dly - 5'd10) >> 1);
        rd  = 4'(cfg.rd_dly - 5'd9);

        mode_reg      = '0;
        mode_reg.addr = mr_idx;
        case (mr_idx)
            MR0_ADDR: begin
                mode_reg.a[1:0] = cfg.burst_length;
                mode_reg.a[2]   = rd[0];
                mode_reg.a[6:4] = rd[3:1];
                mode_reg.a[8]   = 1'b1;
            end
            MR1_ADDR: begin
                mode_reg.a[0]   = 1'b1;
                mode_reg.a[4:3] = cfg.al_dly;
            end
            MR2_ADDR: mode_reg.a[11:9] = wr;
            MR4_ADDR: begin
                mode_reg.a[11] = cfg.r_pre;
                mode_reg.a[12] = cfg.w_pre;
            end
            MR6_ADDR: mode_reg.a[13:10] = cas;
            default: ;
        endcase
    end

endmodule

// File: rtl/ddr4_init_seq.sv
// DDR4 initialisation sequencer: CKE bring-up, per-rank MR3..MR0 programming and ZQCL calibration.
module ddr4_init_seq
    import ddr_package::*;
#(
    parameter int unsigned NUM_RANKS = 1,
    parameter int unsigned T_CKE_L   = 10,
    parameter int unsigned T_IS      = 2,
    parameter int unsigned T_XPR     = 12,
    parameter int unsigned T_MRD     = 8,
    parameter int unsigned T_MOD     = 24,
    parameter int unsigned T_ZQINIT  = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clock_t,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           cas_dly,
    input  logic [4:0]           wr_dly,
    input  logic [4:0]           rd_dly,
    input  logic                 w_pre,
    input  logic                 r_pre,
    input  logic [1:0]           al_dly,
    input  logic [1:0]           burst_length,
    input  logic                 cmd_ready,
    output logic [NUM_RANKS-1:0] cke,
    output logic                 cmd_valid,
    output logic [1:0]           cmd_type,
    output logic [1:0]           cmd_rank,
    output mode_register_type    mode_reg,
    output logic                 busy,
    output logic                 config_done,
    output logic                 cfg_err
);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt, cnt_load;
    logic [1:0]        rank;
    logic [2:0]        step;
    logic [2:0]        mr_idx;
    cfg_t              cfg, cfg_in;
    mode_register_type mr_word;
    logic              wait_done, last_rank, last_step, can_start;

    assign cfg_in    = {cas_dly, wr_dly, rd_dly, w_pre, r_pre, al_dly, burst_length};
    assign wait_done = (cnt == '0);
    assign last_rank = (rank == 2'(NUM_RANKS - 1));
    assign last_step = (step == 3'd6);
    assign can_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign mr_idx    = mr_order(step);

    ddr4_mr_encode u_mr_encode (
        .mr_idx   (mr_idx),
        .cfg      (cfg),
        .mode_reg (mr_word)
    );

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rank  <= '0;
            step  <= '0;
            cfg   <= '0;
        end else begin
            state <= next_state;
            // Every wait state is entered from a different state, so a change of state marks entry.
            if (next_state != state)
                cnt <= cnt_load;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (can_start) begin
                cfg  <= cfg_in;
                rank <= '0;
                step <= '0;
            end
            if (state == MRS_ISSUE && cmd_ready)
                step <= last_step ? 3'd0 : step + 3'd1;
            if (state == ZQ_WAIT && wait_done && !last_rank)
                rank <= rank + 2'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (can_start) next_state = cfg_legal(cfg_in) ? CKE_LOW : ERR;
            CKE_LOW:   if (wait_done) next_state = CKE_SETUP;
            CKE_SETUP: if (wait_done) next_state = XPR_WAIT;
            XPR_WAIT:  if (wait_done) next_state = MRS_ISSUE;
            MRS_ISSUE: if (cmd_ready) next_state = last_step ? MOD_WAIT : MRD_WAIT;
            MRD_WAIT:  if (wait_done) next_state = MRS_ISSUE;
            MOD_WAIT:  if (wait_done) next_state = ZQ_ISSUE;
            ZQ_ISSUE:  if (cmd_ready) next_state = ZQ_WAIT;
            ZQ_WAIT:   if (wait_done) next_state = last_rank ? DONE : MRS_ISSUE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        cnt_load = '0;
        case (next_state)
            CKE_LOW:   cnt_load = CNT_W'(T_CKE_L - 1);
            CKE_SETUP: cnt_load = CNT_W'(T_IS - 1);
            XPR_WAIT:  cnt_load = CNT_W'(T_XPR - 1);
            MRD_WAIT:  cnt_load = CNT_W'(T_MRD - 1);
            MOD_WAIT:  cnt_load = CNT_W'(T_MOD - 1);
            ZQ_WAIT:   cnt_load = CNT_W'(T_ZQINIT - 1);
            default:   cnt_load = '0;
        endcase
    end

    always_comb begin
        cke         = '0;
        busy        = 1'b0;
        cmd_type    = CMD_DES;
        mode_reg    = '0;
        config_done = 1'b0;
        cfg_err     = 1'b0;
        case (state)
            CKE_LOW: busy = 1'b1;
            CKE_SETUP, XPR_WAIT, MRD_WAIT, MOD_WAIT, ZQ_WAIT: begin
                busy = 1'b1;
                cke  = '1;
            end
            MRS_ISSUE: begin
                busy     = 1'b1;
                cke      = '1;
                cmd_type = CMD_MRS;
                mode_reg = mr_word;
            end
            ZQ_ISSUE: begin
                busy     = 1'b1;
                cke      = '1;
                cmd_type = CMD_ZQCL;
                mode_reg = '1;
            end
            DONE: begin
                cke         = '1;
                config_done = 1'b1;
            end
            ERR:     cfg_err = 1'b1;
            default: ;
        endcase
        cmd_valid = busy;
        cmd_rank  = busy ? rank : 2'd0;
    end

endmodule

// File: doc/ddr4_init_seq.md
DDR4_INIT_SEQ -- requirements
Module: ddr4_init_seq

Interface
REQ-001 SHALL have parameter NUM_RANKS, default 1, meaning number of ranks initialised, legal 1..4.
REQ-002 SHALL have parameters T_CKE_L=10, T_IS=2, T_XPR=12, T_MRD=8, T_MOD=24, T_ZQINIT=64, meaning the corresponding delays in clock_t cycles, each >=1.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the wait-counter width; every T_* SHALL be < 2**CNT_W.
REQ-004 clock_t  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  pulse; begins or restarts initialisation.
REQ-007 cas_dly  in  5  CAS latency, legal 9..16.
REQ-008 wr_dly  in  5  write recovery, legal 10..24, even.
REQ-009 rd_dly  in  5  read latency for MR0, legal 9..24.
REQ-010 w_pre, r_pre  in  1 each  write/read preamble select.
REQ-011 al_dly  in  2  additive latency code; burst_length  in  2  BL code.
REQ-012 cmd_ready  in  1  downstream command slot accepts cmd.
REQ-013 cke  out  NUM_RANKS  per-rank clock enable.
REQ-014 cmd_valid  out  1; cmd_type  out  2 (DES/MRS/ZQCL); cmd_rank  out  2; mode_reg  out  mode_register_type.
REQ-015 busy, config_done, cfg_err  out  1 each.

Function
REQ-016 States SHALL be IDLE, CKE_LOW, CKE_SETUP, XPR_WAIT, MRS_ISSUE, MRD_WAIT, MOD_WAIT, ZQ_ISSUE, ZQ_WAIT, DONE, ERR.
REQ-017 IDLE->CKE_LOW on start; at start, cas_dly/wr_dly/rd_dly/w_pre/r_pre/al_dly/burst_length SHALL be captured into registers; later input changes are ignored.
REQ-018 If any captured value is illegal, next state SHALL be ERR (cfg_err=1, busy=0) until reset or start.
REQ-019 Encodings: cas=cas_dly-9 (4 bits), wr=(wr_dly-10)/2 (3 bits), rd=rd_dly-9 (4 bits split rd[3:1], rd[0]); computed at width 5 then truncated.
REQ-020 CKE_LOW holds all cke=0 for T_CKE_L cycles, then all cke=1 and CKE_SETUP for T_IS cycles, then XPR_WAIT for T_XPR cycles.
REQ-021 MRS order per rank SHALL be MR3, MR6, MR5, MR4, MR2, MR1, MR0; ranks processed 0..NUM_RANKS-1 sequentially, full set plus ZQCL per rank.
REQ-022 MRS_ISSUE/ZQ_ISSUE assert cmd_valid=1 with stable cmd_type, cmd_rank, mode_reg until the cycle cmd_ready=1; state advances the following cycle.
REQ-023 After MR3..MR1 acceptance: MRD_WAIT T_MRD cycles; after MR0: MOD_WAIT T_MOD cycles; then ZQ_ISSUE (mode_reg all-ones); after acceptance ZQ_WAIT T_ZQINIT cycles.
REQ-024 After ZQ_WAIT: next rank's MR3 if ranks remain, else DONE.
REQ-025 Outside ISSUE states cmd_type=DES, cmd_valid=1 while busy, mode_reg='0.
REQ-026 DONE: config_done=1, busy=0, cke held 1; start in DONE or ERR re-runs from CKE_LOW.
REQ-027 start while busy SHALL be ignored.
REQ-028 Wait counter loads T-1 on entry and exits at 0, so each wait lasts exactly T cycles; cmd_ready stall cycles add no wait time.
REQ-029 MR field layout equal to the existing DDR4 MR0..MR6 definitions; cas, wr, rd, al_dly, w_pre, r_pre, burst_length placed in their fields.

Reset
REQ-030 While reset=1: state=IDLE, cke=0, cmd_valid=0, cmd_type=DES, cmd_rank=0, mode_reg='0, busy=0, config_done=0, cfg_err=0, counters and captured configuration cleared.
REQ-031 Reset asserted mid-sequence SHALL abort on the next edge with no further command emitted.

Structure
REQ-032 mode_register_type, cmd type enum, state enum and MR address constants SHALL live in ddr_package.
REQ-033 MR word assembly SHALL be a combinational sub-module ddr4_mr_encode (inputs MR index and captured config, output mode_register_type).

Verification
REQ-034 NUM_RANKS=1, cas=11, wr=12, rd=11, cmd_ready=1 -> 7 MRS then ZQCL; MR6 cas field=2, MR2 wr=1, MR0 rd=2; config_done at cycle T_CKE_L+T_IS+T_XPR+6*(T_MRD+1)+1+T_MOD+1+T_ZQINIT after start.
REQ-035 NUM_RANKS=4 -> 28 MRS + 4 ZQCL, cmd_rank 0,0..1..3 in order, config_done once.
REQ-036 cmd_ready low 5 cycles on MR5 -> cmd_valid/mode_reg stable those cycles; completion delayed exactly 5 cycles.
REQ-037 cas_dly=20 -> ERR, cfg_err=1, no MRS issued; then legal start -> normal completion, cfg_err=0.
REQ-038 reset during MRD_WAIT of rank 2 -> all outputs at reset values next cycle; start -> full sequence from rank 0.
REQ-039 start pulse during XPR_WAIT -> ignored; sequence timing unchanged.
